// File: rtl/clk_tick_pkg.sv
// Shared clock-tick constants and helpers for the fabric timer consumers.
package clk_tick_pkg;
  localparam int unsigned CLK_HZ   = 125_000_000;
  localparam int          DIV_W    = 32;
  localparam int unsigned DIV_1MS  = CLK_HZ / 1000;
  localparam int unsigned DIV_10MS = CLK_HZ / 100;
  localparam int unsigned DIV_1S   = CLK_HZ;

  // Channel-select width; a single channel still gets one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_tick_bank_if.sv
// Divisor reload port: valid/ready request plus the error pulse back.
interface clk_tick_bank_if import clk_tick_pkg::*; #(
  parameter int NCH = 4,
  parameter int W   = DIV_W
);
  localparam int CHW = ch_width(NCH);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div;
  logic           cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, active/shadow divisor and tick/wave outputs.
module clk_tick_chan import clk_tick_pkg::*; #(
  parameter int          W           = DIV_W,
  parameter int unsigned DEFAULT_DIV = DIV_1MS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         restart,
  input  logic         ld,
  input  logic [W-1:0] ld_div,
  output logic         tick,
  output logic         wave,
  output logic         pend
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] div_shd_q, div_shd_d;
  logic         pend_q, pend_d;
  logic         tick_q, tick_d;
  logic         wave_q, wave_d;
  logic         at_wrap;

  // div_act is never 0, so cnt never runs past div_act-1.
  assign at_wrap = (cnt_q == div_act_q - W'(1));

  // Next state: restart beats wrap/enable; a pending divisor is only
  // swapped in at a period boundary (wrap, restart or while idle).
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    wave_d    = wave_q;
    if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b0;
      if (pend_q) begin
        div_act_d = div_shd_q;
        pend_d    = 1'b0;
      end
    end else if (en) begin
      if (at_wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        wave_d = ~wave_q;
        if (pend_q) begin
          div_act_d = div_shd_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (pend_q) begin
      div_act_d = div_shd_q;
      pend_d    = 1'b0;
      cnt_d     = '0;
    end
    // A load only arrives when nothing is pending, so it never collides
    // with the apply above; it waits for the next boundary.
    if (ld) begin
      div_shd_d = ld_div;
      pend_d    = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_act_q <= W'(DEFAULT_DIV);
      div_shd_q <= W'(DEFAULT_DIV);
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      wave_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
    end
  end

  assign tick = tick_q;
  assign wave = wave_q;
  assign pend = pend_q;
endmodule

// File: rtl/clk_tick_bank.sv
// Bank of NCH programmable clock-enable generators with a shared reload port.
module clk_tick_bank import clk_tick_pkg::*; #(
  parameter int          NCH         = 4,
  parameter int          W           = DIV_W,
  parameter int unsigned DEFAULT_DIV = DIV_1MS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     en,
  input  logic               sync_restart,
  clk_tick_bank_if.slave     cfg,
  output logic [NCH-1:0]     tick_out,
  output logic [NCH-1:0]     wave_out
);
  localparam int             CHW   = ch_width(NCH);
  localparam logic [CHW:0]   NCH_C = (CHW+1)'(NCH);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] ld;
  logic           ch_ok;
  logic           pend_sel;
  logic           cfg_ready;
  logic           accept;
  logic           good;
  logic           cfg_err_q, cfg_err_d;

  // Config decode: ready mux on the addressed channel, per-channel load
  // strobes, and error flag for zero divisors or out-of-range channels.
  always_comb begin
    ch_ok    = ({1'b0, cfg.cfg_ch} < NCH_C);
    pend_sel = 1'b0;
    ld       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) pend_sel = pend[i];
    end
    cfg_ready = ch_ok ? ~pend_sel : 1'b1;
    accept    = cfg.cfg_valid & cfg_ready;
    good      = accept & ch_ok & (cfg.cfg_div != '0);
    for (int i = 0; i < NCH; i++) begin
      ld[i] = good & (cfg.cfg_ch == CHW'(i));
    end
    cfg_err_d = accept & ~good;
  end

  // Error pulse register: high for exactly one cycle per rejected request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_err_d;
  end

  assign cfg.cfg_ready = cfg_ready;
  assign cfg.cfg_err   = cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_tick_chan #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .restart (sync_restart),
      .ld      (ld[i]),
      .ld_div  (cfg.cfg_div),
      .tick    (tick_out[i]),
      .wave    (wave_out[i]),
      .pend    (pend[i])
    );
  end
endmodule

// File: tb/tb_clk_tick_bank.sv
// Directed bench for clk_tick_bank with a small DEFAULT_DIV.
module tb_clk_tick_bank;
  logic       clk;
  logic       reset;
  logic [3:0] en;
  logic       sync_restart;
  logic [3:0] tick_out, wave_out;
  logic [2:0] en2;
  logic [2:0] tick2, wave2;
  int total = 0;
  int bad   = 0;

  clk_tick_bank_if #(.NCH(4), .W(32)) cfg_if ();
  clk_tick_bank_if #(.NCH(3), .W(32)) cfg2 ();

  clk_tick_bank #(.NCH(4), .W(32), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .sync_restart(sync_restart),
    .cfg(cfg_if), .tick_out(tick_out), .wave_out(wave_out));

  // Second bank with a non power-of-two channel count so an
  // out-of-range channel select is representable.
  clk_tick_bank #(.NCH(3), .W(32), .DEFAULT_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .sync_restart(sync_restart),
    .cfg(cfg2), .tick_out(tick2), .wave_out(wave2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1'b1; en = '0; en2 = '0; sync_restart = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    cfg2.cfg_valid = 1'b0; cfg2.cfg_ch = '0; cfg2.cfg_div = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_reset;
    logic [3:0] et, ew;
    do_reset();
    reset = 1'b1;
    en = 4'hF;
    #2;
    total++; if (tick_out !== 4'h0) begin bad++; $display("FAIL reset_tick got=%h exp=0", tick_out); end
    total++; if (wave_out !== 4'h0) begin bad++; $display("FAIL reset_wave got=%h exp=0", wave_out); end
    total++; if (cfg_if.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_if.cfg_err); end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 4'hF : 4'h0;
      ew = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
      total++; if (tick_out !== et) begin bad++; $display("FAIL run_tick k=%0d got=%h exp=%h", k, tick_out, et); end
      total++; if (wave_out !== ew) begin bad++; $display("FAIL run_wave k=%0d got=%h exp=%h", k, wave_out, ew); end
    end
  endtask

  task test_reload;
    logic [3:0] et;
    logic       er;
    do_reset();
    cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 32'd5; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL reload_idle_pend got=%b exp=0", cfg_if.cfg_ready); end
    step();
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reload_idle_apply got=%b exp=1", cfg_if.cfg_ready); end
    en = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin cfg_if.cfg_div = 32'd3; cfg_if.cfg_valid = 1'b1; end
      step();
      cfg_if.cfg_valid = 1'b0;
      et = (k == 5 || k == 8 || k == 11) ? 4'b0010 : 4'b0000;
      er = !(k == 3 || k == 4);
      total++; if (tick_out !== et) begin bad++; $display("FAIL reload_tick k=%0d got=%h exp=%h", k, tick_out, et); end
      total++; if (cfg_if.cfg_ready !== er) begin bad++; $display("FAIL reload_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready, er); end
    end
  endtask

  task test_wrap_accept;
    logic [3:0] et;
    logic       er;
    do_reset();
    en = 4'b0001;
    cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 32'd2;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) cfg_if.cfg_valid = 1'b1;
      step();
      cfg_if.cfg_valid = 1'b0;
      et = (k == 4 || k == 8 || k == 10 || k == 12) ? 4'b0001 : 4'b0000;
      er = !(k >= 4 && k <= 7);
      total++; if (tick_out !== et) begin bad++; $display("FAIL wrap_acc_tick k=%0d got=%h exp=%h", k, tick_out, et); end
      total++; if (cfg_if.cfg_ready !== er) begin bad++; $display("FAIL wrap_acc_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready, er); end
    end
  endtask

  task test_cfg_err;
    logic [3:0] et;
    logic [2:0] et2;
    do_reset();
    cfg2.cfg_ch = 2'd3; cfg2.cfg_div = 32'd7; cfg2.cfg_valid = 1'b1;
    #1;
    total++; if (cfg2.cfg_ready !== 1'b1) begin bad++; $display("FAIL badch_ready got=%b exp=1", cfg2.cfg_ready); end
    step();
    cfg2.cfg_valid = 1'b0;
    total++; if (cfg2.cfg_err !== 1'b1) begin bad++; $display("FAIL badch_err got=%b exp=1", cfg2.cfg_err); end
    step();
    total++; if (cfg2.cfg_err !== 1'b0) begin bad++; $display("FAIL badch_err_clr got=%b exp=0", cfg2.cfg_err); end
    cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd0; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    total++; if (cfg_if.cfg_err !== 1'b1) begin bad++; $display("FAIL div0_err got=%b exp=1", cfg_if.cfg_err); end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL div0_ready got=%b exp=1", cfg_if.cfg_ready); end
    step();
    total++; if (cfg_if.cfg_err !== 1'b0) begin bad++; $display("FAIL div0_err_clr got=%b exp=0", cfg_if.cfg_err); end
    en = 4'b0100; en2 = 3'b111;
    for (int k = 1; k <= 5; k++) begin
      step();
      et  = (k == 4) ? 4'b0100 : 4'b0000;
      et2 = (k == 4) ? 3'b111 : 3'b000;
      total++; if (tick_out !== et) begin bad++; $display("FAIL div0_keep k=%0d got=%h exp=%h", k, tick_out, et); end
      total++; if (tick2 !== et2) begin bad++; $display("FAIL badch_keep k=%0d got=%h exp=%h", k, tick2, et2); end
    end
  endtask

  task test_disable;
    do_reset();
    en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      step();
      total++; if (tick_out[0] !== (k == 4)) begin bad++; $display("FAIL dis_pre_tick k=%0d got=%b exp=%b", k, tick_out[0], (k == 4)); end
    end
    en = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      total++; if (tick_out[0] !== 1'b0) begin bad++; $display("FAIL dis_tick k=%0d got=%b exp=0", k, tick_out[0]); end
      total++; if (wave_out[0] !== 1'b1) begin bad++; $display("FAIL dis_wave k=%0d got=%b exp=1", k, wave_out[0]); end
    end
    en = 4'b0001;
    step();
    total++; if (tick_out[0] !== 1'b0) begin bad++; $display("FAIL reen_tick1 got=%b exp=0", tick_out[0]); end
    step();
    total++; if (tick_out[0] !== 1'b1) begin bad++; $display("FAIL reen_tick2 got=%b exp=1", tick_out[0]); end
    total++; if (wave_out[0] !== 1'b0) begin bad++; $display("FAIL reen_wave got=%b exp=0", wave_out[0]); end
  endtask

  task test_sync_restart;
    logic [3:0] et, ew;
    do_reset();
    en = 4'b0001;
    repeat (4) step();
    en = 4'b0011;
    step();
    en = 4'b1111;
    cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd6; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    total++; if (wave_out !== 4'b0001) begin bad++; $display("FAIL sync_pre_wave got=%h exp=1", wave_out); end
    total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL sync_pre_ready got=%b exp=0", cfg_if.cfg_ready); end
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    total++; if (tick_out !== 4'h0) begin bad++; $display("FAIL sync_tick got=%h exp=0", tick_out); end
    total++; if (wave_out !== 4'h0) begin bad++; $display("FAIL sync_wave got=%h exp=0", wave_out); end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL sync_ready got=%b exp=1", cfg_if.cfg_ready); end
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 4'b1011 : 4'b0000;
      if (k % 6 == 0) et[2] = 1'b1;
      ew = ((k / 4) % 2 == 1) ? 4'b1011 : 4'b0000;
      if ((k / 6) % 2 == 1) ew[2] = 1'b1;
      total++; if (tick_out !== et) begin bad++; $display("FAIL sync_run_tick k=%0d got=%h exp=%h", k, tick_out, et); end
      total++; if (wave_out !== ew) begin bad++; $display("FAIL sync_run_wave k=%0d got=%h exp=%h", k, wave_out, ew); end
    end
  endtask

  task test_div1_reset;
    logic [3:0] ew;
    do_reset();
    cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 32'd1; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    en = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      step();
      ew = (k % 2 == 1) ? 4'b1000 : 4'b0000;
      total++; if (tick_out !== 4'b1000) begin bad++; $display("FAIL div1_tick k=%0d got=%h exp=8", k, tick_out); end
      total++; if (wave_out !== ew) begin bad++; $display("FAIL div1_wave k=%0d got=%h exp=%h", k, wave_out, ew); end
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (tick_out !== 4'h0) begin bad++; $display("FAIL async_rst_tick got=%h exp=0", tick_out); end
    total++; if (wave_out !== 4'h0) begin bad++; $display("FAIL async_rst_wave got=%h exp=0", wave_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reload();
    test_wrap_accept();
    test_cfg_err();
    test_disable();
    test_sync_restart();
    test_div1_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
